alu_pipe_flags: RTL and testbench

//  Parametrised, registered successor to the EXE-stage ALU. Accepts one operation per cycle

---
 rtl/alu_pipe_flags_if.sv | 27 ++
 rtl/alu_pipe_flags.sv | 142 ++++++++++++++
 tb/tb_alu_pipe_flags.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_flags_if.sv
// Handshake and data bundle for alu_pipe_flags: operation request, registered result and status.
interface alu_pipe_flags_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_command;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             cin;
  logic             s_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       status_register;
  logic             busy;

  modport master (
    output in_valid, alu_command, val1, val2, cin, s_en, out_ready,
    input  in_ready, out_valid, alu_res, status_register, busy
  );

  modport slave (
    input  in_valid, alu_command, val1, val2, cin, s_en, out_ready,
    output in_ready, out_valid, alu_res, status_register, busy
  );
endinterface

// File: rtl/alu_pipe_flags.sv
// Registered EXE-stage ALU with persistent {Z,C,N,V} status register.
// Define ALU_MUL_EN to enable the iterative shift-add multiplier on opcode 1010.
module alu_pipe_flags #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  alu_pipe_flags_if.slave bus
);

  if (WIDTH < 4 || (64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cfg
    $error("alu_pipe_flags: WIDTH must be >= 4 and 2**CNT_W > WIDTH");
  end

  logic [WIDTH-1:0] alu_res_r;
  logic [3:0]       status_r;
  logic             out_valid_r;
  logic             busy_w;
  logic             is_mul;
  logic             accept;

  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH:0]   sum_c;
  logic             ci_c;
  logic             arith_c;
  logic             flag_we_c;
  logic [3:0]       flags_c;

  assign bus.in_ready        = ~busy_w & (~out_valid_r | bus.out_ready);
  assign accept              = bus.in_valid & bus.in_ready;
  assign bus.alu_res         = alu_res_r;
  assign bus.status_register = status_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.busy            = busy_w;

  always_comb begin
    b_c       = bus.val2;
    ci_c      = 1'b0;
    arith_c   = 1'b0;
    flag_we_c = 1'b1;
    res_c     = '0;
    case (bus.alu_command)
      4'b0001: res_c = bus.val2;
      4'b1001: res_c = ~bus.val2;
      4'b0010: arith_c = 1'b1;
      4'b0011: begin arith_c = 1'b1; ci_c = bus.cin; end
      4'b0100: begin arith_c = 1'b1; b_c = ~bus.val2; ci_c = 1'b1; end
      4'b0101: begin arith_c = 1'b1; b_c = ~bus.val2; ci_c = bus.cin; end
      4'b0110: res_c = bus.val1 & bus.val2;
      4'b0111: res_c = bus.val1 | bus.val2;
      4'b1000: res_c = bus.val1 ^ bus.val2;
      default: flag_we_c = 1'b0;
    endcase
    sum_c = {1'b0, bus.val1} + {1'b0, b_c} + {{WIDTH{1'b0}}, ci_c};
    if (arith_c) res_c = sum_c[WIDTH-1:0];
    // Non-arithmetic ops carry C and V forward from the status register.
    flags_c[3] = (res_c == '0);
    flags_c[2] = arith_c ? sum_c[WIDTH] : status_r[2];
    flags_c[1] = res_c[WIDTH-1];
    flags_c[0] = arith_c ? ((bus.val1[WIDTH-1] == b_c[WIDTH-1]) &&
                            (res_c[WIDTH-1] != bus.val1[WIDTH-1]))
                         : status_r[0];
  end

`ifdef ALU_MUL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             mul_s_en;

  assign is_mul = (bus.alu_command == 4'b1010);
  assign busy_w = (state != ST_IDLE);

  // Shift-add: multiplier consumed LSB first, multiplicand shifted up; bits above WIDTH drop out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_s_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            mcand    <= bus.val1;
            mplier   <= bus.val2;
            acc      <= '0;
            cnt      <= '0;
            mul_s_en <= bus.s_en;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign is_mul = 1'b0;
  assign busy_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_r   <= '0;
      status_r    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
      if (accept && !is_mul) begin
        alu_res_r   <= res_c;
        out_valid_r <= 1'b1;
        if (bus.s_en && flag_we_c) status_r <= flags_c;
      end
`ifdef ALU_MUL_EN
      if (state == ST_DONE) begin
        alu_res_r   <= acc;
        out_valid_r <= 1'b1;
        if (mul_s_en) status_r <= {(acc == '0), status_r[2], acc[WIDTH-1], status_r[0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Directed self-checking bench for alu_pipe_flags (WIDTH=32); status is {Z,C,N,V}.
module tb_alu_pipe_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_pipe_flags_if #(.WIDTH(32)) bus ();

  alu_pipe_flags #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op for one edge; expects the DUT ready at the time of the call.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    bus.alu_command = cmd;
    bus.val1        = a;
    bus.val2        = b;
    bus.cin         = c;
    bus.s_en        = s;
    bus.in_valid    = 1'b1;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                    input logic [31:0] b, input logic c, input logic s,
                    input logic [31:0] exp_res, input logic [3:0] exp_st);
    issue(cmd, a, b, c, s);
    check({tag, ".res"}, bus.alu_res, exp_res);
    check({tag, ".st"}, 32'(bus.status_register), 32'(exp_st));
    check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.alu_command = 4'b0000;
    bus.val1        = '0;
    bus.val2        = '0;
    bus.cin         = 1'b0;
    bus.s_en        = 1'b0;
    bus.out_ready   = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res", bus.alu_res, 32'h0);
    check("rst.st", 32'(bus.status_register), 32'h0);
    check("rst.vld", 32'(bus.out_valid), 32'd0);
    check("rst.rdy", 32'(bus.in_ready), 32'd1);
    check("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    //  tag      cmd      val1          val2          cin   s_en  result        ZCNV
    op("add_ov",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 4'b0011);
    op("sub_eq",  4'b0100, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b1100);
    op("and",     4'b0110, 32'h000000FF, 32'h0000000F, 1'b0, 1'b1, 32'h0000000F, 4'b0100);
    op("add_ns",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b0100);
    op("adc",     4'b0011, 32'h00000001, 32'h00000002, 1'b1, 1'b1, 32'h00000004, 4'b0000);
    op("sbc",     4'b0101, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000001, 4'b0100);
    op("sub_ov",  4'b0100, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0101);
    op("mvn",     4'b1001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b0111);
    op("orr_ns",  4'b0111, 32'h000000F0, 32'h0000000F, 1'b0, 1'b0, 32'h000000FF, 4'b0111);
    op("eor",     4'b1000, 32'h0000AAAA, 32'h0000AAAA, 1'b0, 1'b1, 32'h00000000, 4'b1101);
    op("mov",     4'b0001, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 4'b0101);
    op("bad_op",  4'b0000, 32'h00000011, 32'h00000022, 1'b1, 1'b1, 32'h00000000, 4'b0101);

`ifdef ALU_MUL_EN
    begin
      int unsigned n;
      issue(4'b1010, 32'h00010000, 32'h00030000, 1'b0, 1'b1);
      check("mul.busy", 32'(bus.busy), 32'd1);
      check("mul.rdy", 32'(bus.in_ready), 32'd0);
      check("mul.vld0", 32'(bus.out_valid), 32'd0);
      n = 1;
      while (bus.busy && n < 100) begin
        @(posedge clk); #1;
        if (bus.busy) n++;
      end
      check("mul.lat", n, 32'd33);
      check("mul.res", bus.alu_res, 32'h0);
      check("mul.st", 32'(bus.status_register), 32'(4'b1101));
      check("mul.vld", 32'(bus.out_valid), 32'd1);

      issue(4'b1010, 32'h00000007, 32'h00000006, 1'b0, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("mul2.res", bus.alu_res, 32'd42);
      check("mul2.st", 32'(bus.status_register), 32'(4'b0101));
    end
`else
    op("mul_off", 4'b1010, 32'h00000003, 32'h00000004, 1'b0, 1'b1, 32'h00000000, 4'b0101);
    check("mul_off.busy", 32'(bus.busy), 32'd0);
`endif

    // Back-pressure: result held while out_ready is low, new op only taken on release.
    op("bp_mov", 4'b0001, 32'h0, 32'h0000CAFE, 1'b0, 1'b0, 32'h0000CAFE, 4'b0101);
    bus.out_ready   = 1'b0;
    bus.alu_command = 4'b0001;
    bus.val2        = 32'h0000DEAD;
    bus.s_en        = 1'b1;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.rdy", 32'(bus.in_ready), 32'd0);
      check("bp.res", bus.alu_res, 32'h0000CAFE);
      check("bp.vld", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    check("bp.hold", bus.alu_res, 32'h0000CAFE);
    bus.val2      = 32'h0000BEEF;
    bus.out_ready = 1'b1;
    #1;
    check("bp.rel_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.new_res", bus.alu_res, 32'h0000BEEF);
    check("bp.new_st", 32'(bus.status_register), 32'(4'b0101));
    @(posedge clk); #1;
    check("bp.drain", 32'(bus.out_valid), 32'd0);

`ifdef ALU_MUL_EN
    issue(4'b1010, 32'h00000003, 32'h00000005, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    check("mrst.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.busy", 32'(bus.busy), 32'd0);
    check("mrst.res", bus.alu_res, 32'h0);
    check("mrst.st", 32'(bus.status_register), 32'h0);
    check("mrst.vld", 32'(bus.out_valid), 32'd0);
    op("mrst.add", 4'b0010, 32'h2, 32'h3, 1'b0, 1'b1, 32'h5, 4'b0000);
    repeat (40) @(posedge clk);
    #1;
    check("mrst.no_late", bus.alu_res, 32'h5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
